// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 device-to-host frame receiver (optional PS2_RX_GLITCH_FILTER_EN kclk filter)
module ps2_rx_frame #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 2000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       kclk_i,
  input  logic       kdata_i,
  output logic [7:0] keycode_o,
  output logic       keycode_valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] kclk_sync_q;
  logic [SYNC_STAGES-1:0] kdata_sync_q;
  logic                   ks;
  logic                   ks_q;
  logic                   kd;
  logic                   fall;

  // Pin synchronizers; preset high so the idle bus produces no false fall after reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      kclk_sync_q  <= '1;
      kdata_sync_q <= '1;
    end else begin
      kclk_sync_q  <= {kclk_sync_q[SYNC_STAGES-2:0], kclk_i};
      kdata_sync_q <= {kdata_sync_q[SYNC_STAGES-2:0], kdata_i};
    end
  end

`ifdef PS2_RX_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] flt_cnt_q;
  logic          ks_flt_q;

  // kclk only changes level after holding the new value FILTER_LEN consecutive cycles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flt_cnt_q <= '0;
      ks_flt_q  <= 1'b1;
    end else if (kclk_sync_q[SYNC_STAGES-1] != ks_flt_q) begin
      if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
        ks_flt_q  <= kclk_sync_q[SYNC_STAGES-1];
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + FW'(1);
      end
    end else begin
      flt_cnt_q <= '0;
    end
  end

  assign ks = ks_flt_q;
`else
  assign ks = kclk_sync_q[SYNC_STAGES-1];
`endif

  assign kd   = kdata_sync_q[SYNC_STAGES-1];
  assign fall = ks_q & ~ks;

  state_t        state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    keycode_q, keycode_d;
  logic          valid_q, valid_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          timeout;

  assign timeout = (state_q != S_IDLE) && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Deframing FSM and stall timeout; a kclk fall always takes priority over timeout
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    keycode_d = keycode_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    tcnt_d    = (state_q == S_IDLE) ? '0 : tcnt_q + TW'(1);
    if (fall) begin
      tcnt_d = '0;
      case (state_q)
        S_IDLE: begin
          if (!kd) begin
            state_d  = S_DATA;
            bitcnt_d = 3'd0;
          end
        end
        S_DATA: begin
          shreg_d  = {kd, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = kd;
          state_d = S_STOP;
        end
        S_STOP: begin
          if (kd && (^{shreg_q, par_q})) begin
            keycode_d = shreg_q;
            valid_d   = 1'b1;
          end else if (!kd) begin
            ferr_d = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (timeout) begin
      ferr_d  = 1'b1;
      state_d = S_IDLE;
      tcnt_d  = '0;
    end
  end

  // State, datapath and registered strobes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ks_q      <= 1'b1;
      state_q   <= S_IDLE;
      bitcnt_q  <= 3'd0;
      shreg_q   <= 8'h00;
      par_q     <= 1'b0;
      tcnt_q    <= '0;
      keycode_q <= 8'h00;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      ks_q      <= ks;
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      tcnt_q    <= tcnt_d;
      keycode_q <= keycode_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign keycode_o       = keycode_q;
  assign keycode_valid_o = valid_q;
  assign parity_err_o    = perr_q;
  assign frame_err_o     = ferr_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb/tb_ps2_rx_frame.sv - scoreboard bench for ps2_rx_frame
module tb_ps2_rx_frame;

  localparam int HALF = 20;
  localparam int TO   = 200;
  localparam int FL   = 8;

  localparam logic [1:0] EV_VALID = 2'd0;
  localparam logic [1:0] EV_PERR  = 2'd1;
  localparam logic [1:0] EV_FERR  = 2'd2;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       kclk_i = 1'b1;
  logic       kdata_i = 1'b1;
  logic [7:0] keycode_o;
  logic       keycode_valid_o;
  logic       parity_err_o;
  logic       frame_err_o;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] code;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  ps2_rx_frame #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TO),
    .FILTER_LEN     (FL)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .kclk_i          (kclk_i),
    .kdata_i         (kdata_i),
    .keycode_o       (keycode_o),
    .keycode_valid_o (keycode_valid_o),
    .parity_err_o    (parity_err_o),
    .frame_err_o     (frame_err_o)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every strobe must match the oldest expected event
  always @(negedge clk) begin
    if (!rst_i) begin
      int n;
      n = int'(keycode_valid_o) + int'(parity_err_o) + int'(frame_err_o);
      if (n > 1) begin
        checks++;
        errors++;
        $display("FAIL one_strobe: %0d strobes high, required at most 1", n);
      end else if (n == 1) begin
        ev_t e;
        logic [1:0] kind;
        kind = keycode_valid_o ? EV_VALID : (parity_err_o ? EV_PERR : EV_FERR);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: kind %0d code %02h, required none", kind, keycode_o);
        end else begin
          e = exp_q.pop_front();
          if (kind !== e.kind) begin
            errors++;
            $display("FAIL strobe_kind: got %0d, required %0d", kind, e.kind);
          end else if (kind == EV_VALID && keycode_o !== e.code) begin
            errors++;
            $display("FAIL keycode: got %02h, required %02h", keycode_o, e.code);
          end
        end
      end
    end
  end

  task automatic send_bit(input logic b, input bit glitch);
    @(negedge clk);
    kdata_i = b;
    if (glitch) begin
      repeat (6) @(negedge clk);
      kclk_i = 1'b0;
      repeat (3) @(negedge clk);
      kclk_i = 1'b1;
      repeat (HALF - 9) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    kclk_i = 1'b0;
    repeat (HALF) @(negedge clk);
    kclk_i = 1'b1;
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic par, input logic stop);
    ev_t e;
    e.code = d;
    if (!stop)                e.kind = EV_FERR;
    else if (^{d, par} == 1'b1) e.kind = EV_VALID;
    else                      e.kind = EV_PERR;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input bit glitch);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
    send_bit(par, glitch);
    send_bit(stop, glitch);
    @(negedge clk);
    kdata_i = 1'b1;
  endtask

  task automatic good_frame(input logic [7:0] d);
    expect_frame(d, ~^d, 1'b1);
    send_frame(d, ~^d, 1'b1, 1'b0);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (keycode_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_keycode: got %02h, required 00", keycode_o);
    end
    checks++;
    if ({keycode_valid_o, parity_err_o, frame_err_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes: got %b, required 000", {keycode_valid_o, parity_err_o, frame_err_o});
    end
    rst_i = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single;
    good_frame(8'h1C);
    drain(100);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL single_pending: %0d events outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (keycode_o !== 8'h1C) begin
      errors++;
      $display("FAIL single_hold: got %02h, required 1c", keycode_o);
    end
  endtask

  task automatic test_back_to_back;
    good_frame(8'hF0);
    good_frame(8'h1C);
    drain(100);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL b2b_pending: %0d events outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (keycode_o !== 8'h1C) begin
      errors++;
      $display("FAIL b2b_hold: got %02h, required 1c", keycode_o);
    end
  endtask

  task automatic test_parity_err;
    expect_frame(8'h1C, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    drain(100);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL parity_pending: %0d events outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (keycode_o !== 8'h1C) begin
      errors++;
      $display("FAIL parity_hold: got %02h, required 1c", keycode_o);
    end
  endtask

  task automatic test_frame_err;
    expect_frame(8'h5A, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    drain(100);
    checks++;
    if (keycode_o !== 8'h1C) begin
      errors++;
      $display("FAIL stop0_hold: got %02h, required 1c", keycode_o);
    end
    good_frame(8'h5A);
    drain(100);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL stop0_pending: %0d events outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (keycode_o !== 8'h5A) begin
      errors++;
      $display("FAIL stop0_recover: got %02h, required 5a", keycode_o);
    end
  endtask

  task automatic test_timeout;
    ev_t e;
    logic [7:0] d;
    e.kind = EV_FERR;
    e.code = 8'h00;
    exp_q.push_back(e);
    d = 8'h33;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i], 1'b0);
    drain(TO + 100);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL timeout_pending: %0d events outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (keycode_o !== 8'h5A) begin
      errors++;
      $display("FAIL timeout_hold: got %02h, required 5a", keycode_o);
    end
    good_frame(8'h29);
    drain(100);
    checks++;
    if (keycode_o !== 8'h29) begin
      errors++;
      $display("FAIL timeout_recover: got %02h, required 29", keycode_o);
    end
  endtask

  task automatic test_reset_mid;
    ev_t e;
    logic [7:0] d;
    d = 8'h1C;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(d[i], 1'b0);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    // Remnant bit 5 is a 0 and reads as a fresh start; that false frame stalls and times out
    e.kind = EV_FERR;
    e.code = 8'h00;
    exp_q.push_back(e);
    for (int i = 5; i < 8; i++) send_bit(d[i], 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    drain(TO + 100);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL rstmid_pending: %0d events outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (keycode_o !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_keycode: got %02h, required 00", keycode_o);
    end
    good_frame(8'h1C);
    drain(100);
    checks++;
    if (keycode_o !== 8'h1C) begin
      errors++;
      $display("FAIL rstmid_recover: got %02h, required 1c", keycode_o);
    end
  endtask

`ifdef PS2_RX_GLITCH_FILTER_EN
  task automatic test_glitch;
    expect_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
    drain(100);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL glitch_pending: %0d events outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (keycode_o !== 8'h1C) begin
      errors++;
      $display("FAIL glitch_keycode: got %02h, required 1c", keycode_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity_err();
    test_frame_err();
    test_timeout();
    test_reset_mid();
`ifdef PS2_RX_GLITCH_FILTER_EN
    test_glitch();
`endif
    repeat (TO + 50) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL final_pending: %0d events outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
